// File: rtl/ltc2308_pkg.sv
// rtl/ltc2308_pkg.sv - shared widths, frame states and config-word helper for the LTC2308 scanner
package ltc2308_pkg;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;
  localparam int NUM_CH   = 8;
  localparam int CH_W     = 3;

  // Config word fields that never change for this scanner
  localparam logic SD_SINGLE = 1'b1;
  localparam logic UNIPOLAR  = 1'b1;
  localparam logic SLEEP     = 1'b0;

  // Frame state encodings, kept as plain constants for legacy users
  localparam logic [1:0] ST_CONV  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    CONV  = ST_CONV,
    SETUP = ST_SETUP,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } frame_state_e;

  // {S/D, O/S, S1, S0, UNI, SLP}; O/S carries the channel LSB, S1/S0 the upper bits
  function automatic logic [CFG_W-1:0] channel_cfg(input logic [CH_W-1:0] ch);
    return {SD_SINGLE, ch[0], ch[2], ch[1], UNIPOLAR, SLEEP};
  endfunction

endpackage

// File: rtl/ltc2308_frame.sv
// rtl/ltc2308_frame.sv - one CONVST/config/readback transaction, restarting back-to-back
module ltc2308_frame
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CFG_W-1:0]    cfg,
  input  logic                sdo,
  output logic                sclk,
  output logic                convst,
  output logic                sdi,
  output logic [RESULT_W-1:0] result,
  output logic                done
);

  localparam int MAX_CNT = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  frame_state_e        state;
  logic                running;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          bit_idx;
  logic [CFG_W-1:0]    cfg_q;
  logic [RESULT_W-1:0] shreg;
  logic                cnt_last;

  // CONV lasts CONV_CYCLES clocks; every other phase step is one SCLK half-period
  assign cnt_last = (state == CONV) ? (cnt == CONV_LAST) : (cnt == HALF_LAST);
  assign done     = running && (state == GAP) && cnt_last;
  assign result   = shreg;

  // Frame sequencer: registered pins, cfg shifted out MSB first, SDO captured on SCLK rise
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CONV;
      running <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      cfg_q   <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      convst  <= 1'b0;
      sdi     <= 1'b0;
    end else if (!running || done) begin
      running <= 1'b1;
      state   <= CONV;
      cnt     <= '0;
      cfg_q   <= cfg;
      convst  <= 1'b1;
      sclk    <= 1'b0;
      sdi     <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        CONV: begin
          if (cnt_last) begin
            state  <= SETUP;
            cnt    <= '0;
            convst <= 1'b0;
            sdi    <= cfg_q[CFG_W-1];
          end
        end
        SETUP: begin
          if (cnt_last) begin
            state   <= SHIFT;
            cnt     <= '0;
            sclk    <= 1'b1;
            shreg   <= {shreg[RESULT_W-2:0], sdo};
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          if (cnt_last) begin
            cnt <= '0;
            if (sclk) begin
              // zeros shifted in behind cfg[0] keep SDI low for the remaining bits
              sclk  <= 1'b0;
              sdi   <= cfg_q[CFG_W-2];
              cfg_q <= {cfg_q[CFG_W-2:0], 1'b0};
            end else if (bit_idx == 4'(RESULT_W - 1)) begin
              state <= GAP;
            end else begin
              sclk    <= 1'b1;
              shreg   <= {shreg[RESULT_W-2:0], sdo};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        GAP: begin
        end
        default: state <= CONV;
      endcase
    end
  end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// rtl/ltc2308_scan_ctrl.sv - round-robin 8-channel LTC2308 scanner holding the latest result per channel
module ltc2308_scan_ctrl
  import ltc2308_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic                CLOCK,
  input  logic                RESET,
  output logic                ADC_SCLK,
  output logic                ADC_CS_N,
  input  logic                ADC_DOUT,
  output logic                ADC_DIN,
  output logic [RESULT_W-1:0] CH0,
  output logic [RESULT_W-1:0] CH1,
  output logic [RESULT_W-1:0] CH2,
  output logic [RESULT_W-1:0] CH3,
  output logic [RESULT_W-1:0] CH4,
  output logic [RESULT_W-1:0] CH5,
  output logic [RESULT_W-1:0] CH6,
  output logic [RESULT_W-1:0] CH7
);

  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     cfg_ch;
  logic [CH_W-1:0]     wr_idx;
  logic                prev_valid;
  logic                done;
  logic [RESULT_W-1:0] result;
  logic [RESULT_W-1:0] ch_q [NUM_CH];

  // The next frame starts on the same edge the pointer advances, so look one channel ahead
  assign cfg_ch = done ? ptr + 1'b1 : ptr;
  // Readback belongs to the conversion configured one frame earlier
  assign wr_idx = ptr - 1'b1;

  ltc2308_frame #(
    .CLK_DIV    (CLK_DIV),
    .CONV_CYCLES(CONV_CYCLES)
  ) u_frame (
    .clk   (CLOCK),
    .reset (RESET),
    .cfg   (channel_cfg(cfg_ch)),
    .sdo   (ADC_DOUT),
    .sclk  (ADC_SCLK),
    .convst(ADC_CS_N),
    .sdi   (ADC_DIN),
    .result(result),
    .done  (done)
  );

  // Pointer, pipeline-valid flag and per-channel result registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ptr        <= '0;
      prev_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else if (done) begin
      if (prev_valid) ch_q[wr_idx] <= result;
      prev_valid <= 1'b1;
      ptr        <= ptr + 1'b1;
    end
  end

  assign CH0 = ch_q[0];
  assign CH1 = ch_q[1];
  assign CH2 = ch_q[2];
  assign CH3 = ch_q[3];
  assign CH4 = ch_q[4];
  assign CH5 = ch_q[5];
  assign CH6 = ch_q[6];
  assign CH7 = ch_q[7];

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// tb/tb_ltc2308_scan_ctrl.sv - randomized bench with ADC pin model and time-based frame reference
module tb_ltc2308_scan_ctrl;

  localparam int CD0 = 2;
  localparam int CV0 = 80;
  localparam int CD1 = 1;
  localparam int CV1 = 10;

  logic clk;
  logic rst;
  logic sclk_a, csn_a, din_a, dout_a;
  logic sclk_b, csn_b, din_b, dout_b;
  logic [11:0] cha [8];
  logic [11:0] chb [8];

  int checks;
  int errors;
  int cyc;
  int n_m [2];
  logic [11:0] exp_ch [2][8];
  logic [11:0] rnd [256];

  int conv_cnt [2];
  int last_rise [2];
  int hi_cnt [2];
  int pulses [2];
  int last_srise [2];
  int cfg_bits [2];
  logic prev_cs [2];
  logic prev_s [2];
  logic [11:0] res_v [2];
  logic [11:0] sh_v [2];
  logic [5:0] cfg_sh [2];
  logic [5:0] cfg_log [2][64];

  ltc2308_scan_ctrl #(.CLK_DIV(CD0), .CONV_CYCLES(CV0)) dut_a (
    .CLOCK(clk), .RESET(rst), .ADC_SCLK(sclk_a), .ADC_CS_N(csn_a), .ADC_DOUT(dout_a), .ADC_DIN(din_a),
    .CH0(cha[0]), .CH1(cha[1]), .CH2(cha[2]), .CH3(cha[3]),
    .CH4(cha[4]), .CH5(cha[5]), .CH6(cha[6]), .CH7(cha[7])
  );

  ltc2308_scan_ctrl #(.CLK_DIV(CD1), .CONV_CYCLES(CV1)) dut_b (
    .CLOCK(clk), .RESET(rst), .ADC_SCLK(sclk_b), .ADC_CS_N(csn_b), .ADC_DOUT(dout_b), .ADC_DIN(din_b),
    .CH0(chb[0]), .CH1(chb[1]), .CH2(chb[2]), .CH3(chb[3]),
    .CH4(chb[4]), .CH5(chb[5]), .CH6(chb[6]), .CH7(chb[7])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cd_of(input int d);
    return (d == 0) ? CD0 : CD1;
  endfunction

  function automatic int conv_of(input int d);
    return (d == 0) ? CV0 : CV1;
  endfunction

  function automatic int len_of(input int d);
    return conv_of(d) + 26 * cd_of(d);
  endfunction

  function automatic logic [5:0] cfg_of(input int ch);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  // Value the ADC returns for the readback in frame f, converting channel ch
  function automatic logic [11:0] data_for(input int f, input int ch);
    if (f == 0) return 12'hFFF;
    if (f == 11) return 12'hA5A;
    if (f >= 17 && f < 25) return (f % 2 == 1) ? 12'hFFF : 12'h000;
    if (f >= 25) return rnd[f % 256];
    return 12'h100 + 12'(ch);
  endfunction

  function automatic logic [95:0] ch_pack(input int d);
    logic [95:0] p;
    for (int i = 0; i < 8; i++) p[i*12 +: 12] = (d == 0) ? cha[i] : chb[i];
    return p;
  endfunction

  function automatic logic [95:0] exp_pack(input int d);
    logic [95:0] p;
    for (int i = 0; i < 8; i++) p[i*12 +: 12] = exp_ch[d][i];
    return p;
  endfunction

  // Expected {CS_N, SCLK, DIN} at position n (edges since reset release)
  function automatic logic [2:0] pins_exp(input int d, input int n);
    int cd, cv, p, q, k, idx;
    logic hi;
    logic [5:0] cfg;
    cd = cd_of(d);
    cv = conv_of(d);
    p = n % len_of(d);
    cfg = cfg_of((n / len_of(d)) % 8);
    if (p < cv) return 3'b100;
    if (p < cv + cd) return {2'b00, cfg[5]};
    if (p < cv + 25 * cd) begin
      q = p - cv - cd;
      k = q / (2 * cd);
      hi = (q % (2 * cd)) < cd;
      idx = hi ? k : k + 1;
      return {1'b0, hi, (idx < 6) ? cfg[5 - idx] : 1'b0};
    end
    return 3'b000;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic set_dout(input int d, input logic v);
    if (d == 0) dout_a = v;
    else dout_b = v;
  endtask

  // ADC pin model: decodes config from DIN, shifts result MSB first, measures pin timing
  task automatic adc_step(input int d);
    logic cs, s, di;
    int ch;
    cs = (d == 0) ? csn_a : csn_b;
    s  = (d == 0) ? sclk_a : sclk_b;
    di = (d == 0) ? din_a : din_b;
    if (n_m[d] < 0) begin
      conv_cnt[d] = 0;
      last_rise[d] = -1;
      hi_cnt[d] = 0;
      pulses[d] = 0;
      cfg_bits[d] = 0;
      cfg_sh[d] = '0;
      set_dout(d, 1'b0);
    end else begin
      if (cs && !prev_cs[d]) begin
        if (last_rise[d] >= 0) chk("frame_len", 96'(cyc - last_rise[d]), (d == 0) ? 96'd132 : 96'd36);
        if (conv_cnt[d] > 0) chk("sclk_pulses", 96'(pulses[d]), 96'd12);
        last_rise[d] = cyc;
        ch = {29'd0, cfg_sh[d][3], cfg_sh[d][2], cfg_sh[d][4]};
        res_v[d] = data_for(conv_cnt[d], ch);
        conv_cnt[d]++;
        hi_cnt[d] = 0;
        pulses[d] = 0;
        cfg_bits[d] = 0;
      end
      if (cs) begin
        hi_cnt[d]++;
        set_dout(d, 1'($urandom_range(0, 1)));
      end
      if (!cs && prev_cs[d]) begin
        chk("convst_high", 96'(hi_cnt[d]), (d == 0) ? 96'd80 : 96'd10);
        sh_v[d] = res_v[d];
        set_dout(d, sh_v[d][11]);
      end
      if (s && !prev_s[d]) begin
        if (pulses[d] > 0) chk("sclk_period", 96'(cyc - last_srise[d]), (d == 0) ? 96'd4 : 96'd2);
        last_srise[d] = cyc;
        pulses[d]++;
        if (cfg_bits[d] < 6) begin
          cfg_sh[d] = {cfg_sh[d][4:0], di};
          cfg_bits[d]++;
          if (cfg_bits[d] == 6 && conv_cnt[d] - 1 < 64) cfg_log[d][conv_cnt[d] - 1] = cfg_sh[d];
        end
      end
      if (!s && prev_s[d] && !cs) begin
        sh_v[d] = {sh_v[d][10:0], 1'b0};
        set_dout(d, sh_v[d][11]);
      end
    end
    prev_cs[d] = cs;
    prev_s[d] = s;
  endtask

  // Reference frame timeline: position since reset release and completed-frame writes
  initial begin
    int g;
    n_m[0] = -2;
    n_m[1] = -2;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          n_m[d] = -1;
          for (int i = 0; i < 8; i++) exp_ch[d][i] = 12'h000;
        end else if (n_m[d] != -2) begin
          n_m[d]++;
          if (n_m[d] > 0 && n_m[d] % len_of(d) == 0) begin
            g = n_m[d] / len_of(d) - 1;
            if (g >= 1) exp_ch[d][(g - 1) % 8] = data_for(g, (g - 1) % 8);
          end
        end
      end
    end
  end

  // ADC models react mid-cycle to the pins the DUTs drove at the last rising edge
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      prev_cs[d] = 1'b0;
      prev_s[d] = 1'b0;
      last_srise[d] = 0;
      for (int i = 0; i < 64; i++) cfg_log[d][i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) adc_step(d);
    end
  end

  // Per-cycle compare of pins and result buses, plus fixed anchors on the timeline
  initial begin
    int n, L;
    logic [95:0] act;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n = n_m[d];
        if (n >= -1) begin
          act = ch_pack(d);
          if (d == 0) chk("pins_a", 96'({csn_a, sclk_a, din_a}), (n < 0) ? 96'd0 : 96'(pins_exp(d, n)));
          else        chk("pins_b", 96'({csn_b, sclk_b, din_b}), (n < 0) ? 96'd0 : 96'(pins_exp(d, n)));
          chk((d == 0) ? "ch_a" : "ch_b", act, exp_pack(d));
          L = len_of(d);
          if (n == L) chk("discard_frame0", act, 96'd0);
          if (n == 2 * L - 1) chk("ch0_before_f1_end", 96'(act[11:0]), 96'h000);
          if (n == 2 * L) chk("ch0_at_f1_end", 96'(act[11:0]), 96'h100);
          if (n == 9 * L - 1) chk("ch7_before_f8_end", 96'(act[95:84]), 96'h000);
          if (n == 9 * L) chk("full_scan", act, 96'h107106105104103102101100);
          if (n == 12 * L) chk("ch2_rescan", act, 96'h107106105104103A5A101100);
          if (n == 19 * L) chk("extremes", 96'(act[23:0]), 96'h000FFF);
        end
      end
    end
  end

  initial begin
    bit ok;
    logic [5:0] want [6];
    int fr [6];
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rnd[i] = 12'($urandom);
    dout_a = 1'b0;
    dout_b = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_m[0] == 3 * len_of(0) + 92) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_mid_shift", 96'(ok), 96'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (n_m[0] == 33 * len_of(0) + 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_end", 96'(ok), 96'd1);

    want = '{6'b100010, 6'b110010, 6'b110110, 6'b111010, 6'b111110, 6'b100010};
    fr = '{0, 1, 3, 5, 7, 8};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++)
        chk($sformatf("cfg_d%0d_f%0d", d, fr[i]), 96'(cfg_log[d][fr[i]]), 96'(want[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
